// File: rtl/alu_issuer_pkg.sv
// Shared encodings and types for the ALU issuer: op codes, FSM states and
// the response record carried through the response FIFO.
package alu_issuer_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_CAPT  = 2'd2;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  function automatic logic op_supported(input logic [3:0] op);
    return op <= OP_ADD;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO, power-of-two depth, asynchronous active-high reset.
// Head output reads as zero while empty so idle outputs are clean.
module alu_rsp_fifo
  import alu_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rsp_t push_data,
  input  logic pop,
  output rsp_t head,
  output logic empty,
  output logic full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CntMax = (AW + 1)'(DEPTH);

  rsp_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CntMax);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_issuer.sv
// Issues one command at a time to a registered downstream ALU, captures the
// result two edges later and queues {tag, data, err}. Optional: ALU_ISSUER_STATS_EN.
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [15:0] stat_cnt
`endif
);

  state_t     state_q, state_d;
  logic [3:0] tag_cnt_q, inflight_tag_q;
  logic       inflight_err_q;
  logic       accept, push, fifo_empty, fifo_full;
  rsp_t       push_rsp, head;

  assign cmd_ready = (state_q == ST_IDLE) && !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state_q == ST_CAPT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_DRIVE;
      ST_DRIVE: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      tag_cnt_q      <= '0;
      inflight_tag_q <= '0;
      inflight_err_q <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_sel        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a          <= cmd_a;
        alu_b          <= cmd_b;
        alu_sel        <= op_supported(cmd_op) ? cmd_op : OP_AND;
        inflight_tag_q <= tag_cnt_q;
        inflight_err_q <= !op_supported(cmd_op);
        tag_cnt_q      <= tag_cnt_q + 1'b1;
      end
    end
  end

  // Unsupported ops still run the ALU (as AND) for uniform timing; result is masked.
  always_comb begin
    push_rsp.tag  = inflight_tag_q;
    push_rsp.data = inflight_err_q ? 32'h0 : alu_out;
    push_rsp.err  = inflight_err_q;
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rsp),
    .pop       (rsp_ready),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head.data;
  assign rsp_tag   = head.tag;
  assign rsp_err   = head.err;

`ifdef ALU_ISSUER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt <= '0;
    end else if (push && (stat_cnt != 16'hFFFF)) begin
      stat_cnt <= stat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: vector table, scoreboard queue and
// hand-written sequences for timing, backpressure, tag wrap and mid-op reset.
module tb_alu_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
`ifdef ALU_ISSUER_STATS_EN
  logic [15:0] stat_cnt;
`endif

  alu_issuer #(
    .RSP_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err)
`ifdef ALU_ISSUER_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Downstream registered ALU.
  always @(posedge clk) begin
    case (alu_sel)
      4'd0:    alu_out <= alu_a & alu_b;
      4'd1:    alu_out <= alu_a | alu_b;
      4'd2:    alu_out <= alu_a ^ alu_b;
      4'd3:    alu_out <= alu_a + alu_b;
      default: alu_out <= 32'h0;
    endcase
  end

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  exp_t       q[$];
  logic [3:0] exp_tag;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare each popped response against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got tag %h data %h with no expectation", rsp_tag,
                 rsp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_tag", {28'h0, rsp_tag}, {28'h0, e.tag});
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [31:0] exp, input logic err, input bit track);
    int   n = 0;
    exp_t e;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", {31'h0, cmd_ready}, 32'h1);
      cmd_valid = 1'b0;
    end else begin
      if (track) begin
        e.tag = exp_tag;
        e.data = exp;
        e.err = err;
        q.push_back(e);
      end
      exp_tag = exp_tag + 4'd1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(q.size() == 0 && !rsp_valid && !cmd_valid && cmd_ready) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", {31'h0, (q.size() == 0)}, 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    exp_tag = 4'd0;
    rst = 1'b0;
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [3:0] t0;

    vecs[0] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd0, 32'h00F0_00F0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'h1234_5678, 32'h0F0F_0000, 4'd1, 32'h1F3F_5678, 1'b0};
    vecs[3] = '{32'hAAAA_5555, 32'hFFFF_0000, 4'd2, 32'h5555_5555, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 32'h8000_0000, 1'b0};
    vecs[5] = '{32'hDEAD_BEEF, 32'h1234_5678, 4'd7, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_0001, 32'h0000_0002, 4'd15, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h0000_0010, 32'h0000_0020, 4'd3, 32'h0000_0030, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    rsp_ready = 1'b0;
    exp_tag = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_rsp_tag", {28'h0, rsp_tag}, 32'h0);
    check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("reset_alu_a", alu_a, 32'h0);
    check("reset_alu_b", alu_b, 32'h0);
    check("reset_alu_sel", {28'h0, alu_sel}, 32'h0);
    rst = 1'b0;
    check("release_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // First-command timing: accept at edge 0, response visible after edge 2.
    cmd_a = 32'hF0F0_F0F0;
    cmd_b = 32'h0FF0_0FF0;
    cmd_op = 4'd0;
    cmd_valid = 1'b1;
    e.tag = exp_tag;
    e.data = 32'h00F0_00F0;
    e.err = 1'b0;
    q.push_back(e);
    exp_tag = exp_tag + 4'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("drive_alu_a", alu_a, 32'hF0F0_F0F0);
    check("drive_alu_b", alu_b, 32'h0FF0_0FF0);
    check("drive_alu_sel", {28'h0, alu_sel}, 32'h0);
    check("drive_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("capt_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("capt_alu_a_hold", alu_a, 32'hF0F0_F0F0);
    @(posedge clk);
    #1;
    check("edge2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("edge2_rsp_data", rsp_data, 32'h00F0_00F0);
    check("edge2_rsp_tag", {28'h0, rsp_tag}, 32'h0);
    check("edge2_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("edge2_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    rsp_ready = 1'b1;
    wait_drain();

    // Unsupported op drives select 0 while in flight.
    send(32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'd7, 32'h0, 1'b1, 1'b1);
    check("unsup_alu_sel", {28'h0, alu_sel}, 32'h0);
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].err, 1'b1);
    end
    wait_drain();

    // Backpressure: four buffered, fifth held until space frees.
    rsp_ready = 1'b0;
    t0 = exp_tag;
    for (int i = 0; i < 4; i++) begin
      send(32'h100 + i, 32'h1, 4'd3, 32'h101 + i, 1'b0, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    check("full_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check("full_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    fork
      send(32'h200, 32'h4, 4'd1, 32'h204, 1'b0, 1'b1);
    join_none
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("held_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      check("held_rsp_tag", {28'h0, rsp_tag}, {28'h0, t0});
      check("held_rsp_data", rsp_data, 32'h101);
    end
    rsp_ready = 1'b1;
    wait_drain();

    // Tag wrap over 18 back-to-back commands.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      send(i, i * 3, 4'd3, i * 4, 1'b0, 1'b1);
    end
    wait_drain();

    // Reset while a command is in DRIVE: it must vanish.
    send(32'h55, 32'h0F, 4'd0, 32'h05, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    q.delete();
    exp_tag = 4'd0;
    rst = 1'b0;
    check("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("midrst_alu_a", alu_a, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    send(32'h3, 32'h4, 4'd3, 32'h7, 1'b0, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter: RSP_DEPTH, default 4, response FIFO depth (power of two, >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  issuer accepts command this cycle.
REQ-006 cmd_a, cmd_b  input  32 each  operands.
REQ-007 cmd_op  input  4  operation: 0 AND, 1 OR, 2 XOR, 3 ADD; 4..15 unsupported.
REQ-008 alu_a, alu_b  output  32 each  operands driven to the downstream registered ALU.
REQ-009 alu_sel  output  4  select driven to the ALU.
REQ-010 alu_out  input  32  ALU result, registered by the ALU one clk after sampling alu_a/alu_b/alu_sel.
REQ-011 rsp_valid  output  1  response at FIFO head.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_data  output  32  result.
REQ-014 rsp_tag  output  4  sequence tag of originating command.
REQ-015 rsp_err  output  1  unsupported op.

Function
REQ-016 FSM states IDLE, DRIVE, CAPT; IDLE->DRIVE on cmd_valid&&cmd_ready; DRIVE->CAPT unconditionally; CAPT->IDLE unconditionally.
REQ-017 cmd_ready = (state==IDLE) && FIFO not full; combinational, no dependence on cmd_valid.
REQ-018 On accept (edge N): alu_a/alu_b/alu_sel registered from cmd_*; held stable through DRIVE and CAPT.
REQ-019 At edge N+2 (leaving CAPT): {tag, alu_out, err} pushed; rsp_valid high from N+2 if FIFO was empty; throughput one command per 3 cycles.
REQ-020 Unsupported op: alu_sel driven 0, same timing, pushed rsp_data=0, rsp_err=1.
REQ-021 Tag counter 4 bits, increments per accepted command, wraps 15->0; response carries the tag of its command.
REQ-022 FIFO order strict; pop on rsp_valid&&rsp_ready; rsp_* stable while rsp_valid&&!rsp_ready.
REQ-023 Simultaneous push and pop: both occur, count unchanged; push never occurs while full (guaranteed by REQ-017).
REQ-024 FIFO full: cmd_ready low; in-flight command still completes (space reserved at accept).
REQ-025 Pointers wrap modulo RSP_DEPTH; count range 0..RSP_DEPTH.

Reset
REQ-026 rst asserted: state=IDLE, FIFO empty, tag=0, alu_a=alu_b=0, alu_sel=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0.
REQ-027 rst mid-operation: in-flight command discarded, no response produced; cmd_ready high first cycle after release.

Configuration
REQ-028 ALU_ISSUER_STATS_EN defined: extra output stat_cnt (16 bits) counts pushed responses, saturating at 0xFFFF, reset 0.
REQ-029 ALU_ISSUER_STATS_EN undefined: stat_cnt port and logic absent; all other behaviour identical.

Structure
REQ-030 Package alu_issuer_pkg: op encodings (OP_AND..OP_ADD), FSM state enum, response struct {tag, data, err}.
REQ-031 Sub-module alu_rsp_fifo: parameterised synchronous FIFO, one clock, asynchronous active-high rst.

Verification
REQ-032 a=0xF0F0_F0F0, b=0x0FF0_0FF0, op=0 accepted edge 0 -> rsp_valid at edge 2, rsp_data=0x00F0_00F0, tag=0, err=0.
REQ-033 a=0xFFFF_FFFF, b=1, op=3 -> rsp_data=0x0000_0000, err=0 (carry out discarded).
REQ-034 op=7 -> rsp_data=0, rsp_err=1, alu_sel=0 during DRIVE.
REQ-035 rsp_ready=0, issue 5 commands with RSP_DEPTH=4 -> 4 responses buffered, cmd_ready low, 5th held; rsp_ready=1 -> tags 0..4 in order.
REQ-036 18 back-to-back commands -> tags 0..15,0,1 (wrap); rst asserted in DRIVE -> no response, FIFO empty, tag=0.
